// File: rtl/stream_mux_arb.sv
// Stream multiplexer: CH valid/ready inputs are merged onto one registered output.
// Arbitration is round-robin or by external select, and a packet holds its grant until its last beat.
module stream_mux_arb #(
  parameter  int n    = 32,
  parameter  int CH   = 4,
  parameter  int MODE = 0,
  localparam int SW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*n-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH-1:0]   in_last,
  output logic [CH-1:0]   in_ready,
  input  logic [SW-1:0]   sel,
  output logic [n-1:0]    out_data,
  output logic            out_valid,
  output logic            out_last,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] lock_ch, rr_ptr;
  logic [CH-1:0] grant;
  logic          load, xfer, xfer_last, found;
  logic [SW-1:0] xfer_ch;
  logic [n-1:0]  xfer_data;
  int            idx;

  assign load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= SW'(CH-1);
    end else begin
      state <= state_nxt;
      if (xfer) begin
        if (xfer_last) rr_ptr  <= xfer_ch;
        else           lock_ch <= xfer_ch;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = xfer_last ? IDLE : LOCKED;
  end

  // A locked channel keeps its grant even while it has no valid beat.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (state == LOCKED) begin
      for (int i = 0; i < CH; i++) grant[i] = (lock_ch == SW'(i));
    end else if (MODE != 0) begin
      for (int i = 0; i < CH; i++) grant[i] = in_valid[i] && (sel == SW'(i));
    end else begin
      for (int k = 1; k <= CH; k++) begin
        idx = (int'(rr_ptr) + k) % CH;
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    xfer_ch   = '0;
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        xfer_ch   = SW'(i);
        xfer_data = in_data[i*n +: n];
        xfer_last = in_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= xfer_data;
        out_last <= xfer_last;
        out_ch   <= xfer_ch;
      end
    end
  end

endmodule
